// File: rtl/fuel_pump_guard.sv
// Anti-theft fuel pump interlock: ignition, hidden switch, then brake within a window.
// Repeated failed attempts force a timed lockout during which all inputs are ignored.
module fuel_pump_guard #(
  parameter int WINDOW_CYCLES  = 8,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 50
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              brake,
  input  logic                              hidden_sw,
  input  logic                              ignition,
  output logic                              fuel_pump,
  output logic                              lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_cnt
);

  localparam int MAXC = (WINDOW_CYCLES > LOCKOUT_CYCLES) ?
                        WINDOW_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam int FW = $clog2(MAX_ATTEMPTS + 1);

  localparam logic [TW-1:0] WIN    = TW'(WINDOW_CYCLES);
  localparam logic [TW-1:0] LOCK_T = TW'(LOCKOUT_CYCLES);
  localparam logic [TW-1:0] ONE_T  = TW'(1);
  localparam logic [FW-1:0] MAXF   = FW'(MAX_ATTEMPTS);
  localparam logic [FW-1:0] LAST   = FW'(MAX_ATTEMPTS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SW  = 3'd1,
    WAIT_BRK = 3'd2,
    PUMP_ON  = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [FW-1:0] fail_n;
  logic          brake_q;
  logic          brk_edge;
  logic          fail_hit;

  assign brk_edge = brake & ~brake_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      fail_cnt <= '0;
      brake_q  <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      fail_cnt <= fail_n;
      brake_q  <= brake;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    fail_n   = fail_cnt;
    fail_hit = 1'b0;
    case (state)
      IDLE: begin
        if (ignition) state_n = WAIT_SW;
      end
      WAIT_SW: begin
        if (!ignition) begin
          state_n = IDLE;
        end else if (hidden_sw) begin
          // a brake edge arriving with the switch is swallowed here
          state_n = WAIT_BRK;
          timer_n = WIN;
        end else if (brk_edge) begin
          fail_hit = 1'b1;
        end
      end
      WAIT_BRK: begin
        if (!ignition) begin
          state_n = IDLE;
        end else if (brk_edge) begin
          state_n = PUMP_ON;
          fail_n  = '0;
        end else if (timer == ONE_T) begin
          fail_hit = 1'b1;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      PUMP_ON: begin
        if (!ignition) state_n = IDLE;
      end
      LOCKOUT: begin
        if (timer == ONE_T) begin
          state_n = IDLE;
          fail_n  = '0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (fail_hit) begin
      if (fail_cnt == LAST) begin
        state_n = LOCKOUT;
        timer_n = LOCK_T;
        fail_n  = MAXF;
      end else begin
        state_n = WAIT_SW;
        fail_n  = fail_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    fuel_pump = (state == PUMP_ON);
    lockout   = (state == LOCKOUT);
  end

endmodule
